// File: rtl/obstacle_scheduler_pkg.sv
// Shared constants for the obstacle spawn scheduler and its LFSR.
// FSM encoding, LFSR seed/taps and the LFSR step function.
package obstacle_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_PICK  = 2'd2;
    localparam logic [1:0] ST_ISSUE = 2'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 as bits 7,5,4,3 of the left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, shared by spawn, traffic and colour logic.
// Seeded non-zero on reset, so it never locks up at zero.
module lfsr8
    import obstacle_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = lfsr_step(q_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawns rival cars into free obstacle slots on a fixed upsig cadence.
// Round-robin free-slot search, pseudo-random x, registered init pulse.
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int N_SLOTS      = 4,
    parameter int SPAWN_PERIOD = 120,
    parameter int X_MIN        = 40,
    parameter int X_MASK       = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               upsig,
    input  logic [N_SLOTS-1:0] slot_on,
    output logic [N_SLOTS-1:0] init,
    output logic [7:0]         initial_x,
    output logic               missed_spawn,
    output logic [15:0]        spawn_count
);

    localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int TW = $clog2(SPAWN_PERIOD);
    localparam logic [TW-1:0] TMAX = TW'(SPAWN_PERIOD - 1);
    localparam logic [IW-1:0] LAST = IW'(N_SLOTS - 1);

    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      slot_idx_q, slot_idx_d;
    logic [N_SLOTS-1:0] init_q, init_d;
    logic [7:0]         initial_x_q, initial_x_d;
    logic               missed_q, missed_d;
    logic [15:0]        count_q, count_d;

    logic [7:0]    lfsr;
    logic [7:0]    spawn_x;
    logic          found;
    logic [IW-1:0] pick_idx;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    function automatic logic [IW-1:0] wrap_idx(
        input logic [IW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= N_SLOTS) s = s - N_SLOTS;
        return IW'(s);
    endfunction

    // Walk offsets high to low so the nearest free slot wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!slot_on[wrap_idx(rr_ptr_q, i)]) begin
                found    = 1'b1;
                pick_idx = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    assign spawn_x = 8'(X_MIN) + (lfsr & 8'(X_MASK));

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rr_ptr_d    = rr_ptr_q;
        slot_idx_d  = slot_idx_q;
        init_d      = '0;
        initial_x_d = initial_x_q;
        missed_d    = 1'b0;
        count_d     = count_q;

        // Ticks keep counting through PICK/ISSUE so the cadence stays exact.
        if (upsig && state_q != ST_IDLE) begin
            timer_d = (timer_q == TMAX) ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (enable) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (upsig && timer_q == TMAX) state_d = ST_PICK;
            end
            ST_PICK: begin
                if (found) begin
                    slot_idx_d       = pick_idx;
                    init_d[pick_idx] = 1'b1;
                    initial_x_d      = spawn_x;
                    state_d          = ST_ISSUE;
                end else begin
                    missed_d = 1'b1;
                    state_d  = ST_COUNT;
                end
            end
            ST_ISSUE: begin
                rr_ptr_d = (slot_idx_q == LAST) ? '0 : slot_idx_q + 1'b1;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                state_d = ST_COUNT;
            end
            default: state_d = ST_IDLE;
        endcase

        // An init already on the wire still books its rr_ptr/count update.
        if (!enable && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            init_d      = '0;
            missed_d    = 1'b0;
            initial_x_d = initial_x_q;
            slot_idx_d  = slot_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            rr_ptr_q    <= '0;
            slot_idx_q  <= '0;
            init_q      <= '0;
            initial_x_q <= '0;
            missed_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rr_ptr_q    <= rr_ptr_d;
            slot_idx_q  <= slot_idx_d;
            init_q      <= init_d;
            initial_x_q <= initial_x_d;
            missed_q    <= missed_d;
            count_q     <= count_d;
        end
    end

    assign init         = init_q;
    assign initial_x    = initial_x_q;
    assign missed_spawn = missed_q;
    assign spawn_count  = count_q;

endmodule
